// File: rtl/reaction_game_ctrl_if.sv
// Button/tick inputs and LED/score outputs of the reaction game controller.
// master drives buttons and tick, slave is the controller itself.
interface reaction_game_ctrl_if #(
  parameter int SCORE_W = 13
);
  logic               buttonStart;
  logic               buttonHit;
  logic               tick;
  logic               ledRed;
  logic               ledGreen;
  logic               ledFoul;
  logic               busy;
  logic               done;
  logic [3:0]         roundIdx;
  logic [SCORE_W-1:0] roundScore;
  logic [SCORE_W-1:0] bestScore;
  logic [SCORE_W+3:0] totalScore;

  modport master (
    output buttonStart, buttonHit, tick,
    input  ledRed, ledGreen, ledFoul, busy, done,
    input  roundIdx, roundScore, bestScore, totalScore
  );

  modport slave (
    input  buttonStart, buttonHit, tick,
    output ledRed, ledGreen, ledFoul, busy, done,
    output roundIdx, roundScore, bestScore, totalScore
  );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Multi-round reaction game: LFSR-randomised red delay, green tick counter, foul/timeout, score tracking.
// LEDs follow a causing edge by 1 cycle, roundScore by 2; inputs are levels, no backpressure.
module reaction_game_ctrl #(
  parameter int          SCORE_W   = 13,
  parameter int          ROUNDS    = 3,
  parameter int          DELAY_MIN = 500,
  parameter int          RAND_W    = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                 Clock,
  input logic                 buttonReset,
  reaction_game_ctrl_if.slave io
);
  localparam int DW = (SCORE_W > RAND_W + 1) ? SCORE_W : RAND_W + 1;
  localparam int TW = SCORE_W + 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [3:0]         LAST_IDX  = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, ARM, GO, RECORD, FOUL, DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               start_prev_q, hit_prev_q;
  logic [DW-1:0]      delay_q, delay_d;
  logic [SCORE_W-1:0] count_q, count_d;
  logic [SCORE_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [TW-1:0]      total_q, total_d;
  logic [3:0]         idx_q, idx_d;
  logic               start_edge, hit_edge;
  logic [DW-1:0]      delay_load;

  assign start_edge = io.buttonStart & ~start_prev_q;
  assign hit_edge   = io.buttonHit & ~hit_prev_q;
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign delay_load = DW'(DELAY_MIN) + DW'(lfsr_q[RAND_W-1:0]);

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    count_d = count_q;
    round_d = round_q;
    best_d  = best_q;
    total_d = total_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          state_d = ARM;
          idx_d   = '0;
          round_d = '0;
          total_d = '0;
          best_d  = SCORE_MAX;
          delay_d = delay_load;
        end
      end
      ARM: begin
        // A hit always beats the tick that would have turned the light green.
        if (hit_edge) begin
          state_d = FOUL;
        end else if (io.tick) begin
          if (delay_q <= DW'(1)) begin
            state_d = GO;
            count_d = '0;
          end else begin
            delay_d = delay_q - DW'(1);
          end
        end
      end
      GO: begin
        if (hit_edge) begin
          state_d = RECORD;
        end else if (io.tick) begin
          if (count_q == SCORE_MAX) state_d = FOUL;
          else                      count_d = count_q + SCORE_W'(1);
        end
      end
      RECORD: begin
        round_d = count_q;
        total_d = total_q + TW'(count_q);
        best_d  = (count_q < best_q) ? count_q : best_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          delay_d = delay_load;
          state_d = ARM;
        end
      end
      FOUL: begin
        if (start_edge) begin
          delay_d = delay_load;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (buttonReset) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      start_prev_q <= 1'b0;
      hit_prev_q   <= 1'b0;
      delay_q      <= '0;
      count_q      <= '0;
      round_q      <= '0;
      best_q       <= SCORE_MAX;
      total_q      <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= io.buttonStart;
      hit_prev_q   <= io.buttonHit;
      delay_q      <= delay_d;
      count_q      <= count_d;
      round_q      <= round_d;
      best_q       <= best_d;
      total_q      <= total_d;
      idx_q        <= idx_d;
    end
  end

  assign io.ledRed     = (state_q == ARM);
  assign io.ledGreen   = (state_q == GO);
  assign io.ledFoul    = (state_q == FOUL);
  assign io.done       = (state_q == DONE);
  assign io.busy       = (state_q == ARM) | (state_q == GO) | (state_q == RECORD) | (state_q == FOUL);
  assign io.roundIdx   = idx_q;
  assign io.roundScore = round_q;
  assign io.bestScore  = best_q;
  assign io.totalScore = total_q;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: DUT A (13-bit scores, 2 rounds) and DUT B (4-bit scores, 3 rounds),
// both with a 4..5 tick red delay; one stimulus bus steered by sel.
module tb_reaction_game_ctrl;
  localparam int SW_A = 13;
  localparam int SW_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_s, hit_s, tick_s;
  bit   sel;

  reaction_game_ctrl_if #(.SCORE_W(SW_A)) if_a ();
  reaction_game_ctrl_if #(.SCORE_W(SW_B)) if_b ();

  assign if_a.buttonStart = start_s & ~sel;
  assign if_a.buttonHit   = hit_s   & ~sel;
  assign if_a.tick        = tick_s  & ~sel;
  assign if_b.buttonStart = start_s & sel;
  assign if_b.buttonHit   = hit_s   & sel;
  assign if_b.tick        = tick_s  & sel;

  reaction_game_ctrl #(.SCORE_W(SW_A), .ROUNDS(2), .DELAY_MIN(4), .RAND_W(1), .LFSR_SEED(16'hACE1))
    dut_a (.Clock(clk), .buttonReset(rst), .io(if_a));
  reaction_game_ctrl #(.SCORE_W(SW_B), .ROUNDS(3), .DELAY_MIN(4), .RAND_W(1), .LFSR_SEED(16'hACE1))
    dut_b (.Clock(clk), .buttonReset(rst), .io(if_b));

  // Reference LFSR: Fibonacci, taps 16,14,13,11, runs in lockstep with both DUTs.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  logic        o_red, o_green, o_foul, o_busy, o_done;
  logic [3:0]  o_idx;
  logic [12:0] o_round, o_best;
  logic [16:0] o_total;
  always_comb begin
    o_red = if_a.ledRed; o_green = if_a.ledGreen; o_foul = if_a.ledFoul;
    o_busy = if_a.busy; o_done = if_a.done; o_idx = if_a.roundIdx;
    o_round = if_a.roundScore; o_best = if_a.bestScore; o_total = if_a.totalScore;
    if (sel) begin
      o_red = if_b.ledRed; o_green = if_b.ledGreen; o_foul = if_b.ledFoul;
      o_busy = if_b.busy; o_done = if_b.done; o_idx = if_b.roundIdx;
      o_round = 13'(if_b.roundScore); o_best = 13'(if_b.bestScore); o_total = 17'(if_b.totalScore);
    end
  end

  int checks = 0;
  int failures = 0;

  typedef struct {bit dut; int ticks;} vec_t;
  typedef struct {logic [12:0] round; logic [12:0] best; logic [16:0] total;} exp_t;
  vec_t vecs[5];
  exp_t exp_q[$];

  function automatic logic [12:0] all_ones(input bit d);
    return d ? 13'h000F : 13'h1FFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input logic s, input logic h, input logic t);
    start_s = s; hit_s = h; tick_s = t;
    @(negedge clk);
  endtask

  task automatic wait_green();
    for (int i = 0; i < 20; i++) begin
      if (o_green) break;
      step(1'b0, 1'b0, 1'b1);
    end
    chk("wait_green", o_green, 1);
  endtask

  task automatic run_table(input bit d);
    logic [12:0] m_best;
    logic [16:0] m_total;
    exp_t e;
    m_best = all_ones(d);
    m_total = '0;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].dut == d) begin
        wait_green();
        repeat (vecs[i].ticks) step(1'b0, 1'b0, 1'b1);
        m_total = m_total + 17'(vecs[i].ticks);
        if (13'(vecs[i].ticks) < m_best) m_best = 13'(vecs[i].ticks);
        e.round = 13'(vecs[i].ticks); e.best = m_best; e.total = m_total;
        exp_q.push_back(e);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        chk("tbl_round", o_round, e.round);
        chk("tbl_best", o_best, e.best);
        chk("tbl_total", o_total, e.total);
      end
    end
  endtask

  initial begin
    int d1, d2;
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int dly;
    vecs[0] = '{1'b0, 7};
    vecs[1] = '{1'b0, 7};
    vecs[2] = '{1'b1, 9};
    vecs[3] = '{1'b1, 5};
    vecs[4] = '{1'b1, 12};

    rst = 1'b1; start_s = 1'b0; hit_s = 1'b0; tick_s = 1'b0; sel = 1'b0;
    @(negedge clk);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_red", o_red, 0);
    chk("rst_green", o_green, 0);
    chk("rst_foul", o_foul, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_round", o_round, 0);
    chk("rst_total", o_total, 0);
    chk("rst_best_a", o_best, 13'h1FFF);
    sel = 1'b1; #1;
    chk("rst_best_b", o_best, 13'h000F);
    sel = 1'b0; #1;
    rst = 1'b0;
    step(0, 0, 0);

    // Two clean rounds of 7 ticks on DUT A.
    step(1, 0, 0);
    chk("start_red", o_red, 1);
    chk("start_busy", o_busy, 1);
    step(0, 0, 0);
    run_table(1'b0);
    chk("g1_done", o_done, 1);
    chk("g1_busy", o_busy, 0);
    chk("g1_total", o_total, 14);
    chk("g1_best", o_best, 7);

    // False start in ARM, retry, then score normally.
    step(1, 0, 0);
    chk("g2_red", o_red, 1);
    chk("g2_total_clr", o_total, 0);
    chk("g2_best_clr", o_best, 13'h1FFF);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("fs_foul", o_foul, 1);
    chk("fs_red", o_red, 0);
    chk("fs_idx", o_idx, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("fs_retry_red", o_red, 1);
    step(0, 0, 0);
    wait_green();
    repeat (3) step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("fs_round", o_round, 3);
    chk("fs_idx1", o_idx, 1);

    // Hit coincident with final ARM tick, then hit coincident with a GO tick.
    step(0, 1, 0);
    chk("co_foul0", o_foul, 1);
    step(0, 0, 0);
    dly = 4 + int'(m_lfsr[0]);
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (dly - 1) step(0, 0, 1);
    chk("co_still_red", o_red, 1);
    step(0, 1, 1);
    chk("co_final_foul", o_foul, 1);
    chk("co_final_green", o_green, 0);
    step(0, 0, 0);
    dly = 4 + int'(m_lfsr[0]);
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (dly - 1) step(0, 0, 1);
    chk("co_pre_green", o_green, 0);
    step(0, 0, 1);
    chk("co_green", o_green, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    chk("co_round", o_round, 1);
    chk("co_done", o_done, 1);
    chk("co_total", o_total, 4);
    chk("co_best", o_best, 1);

    // Reset in GO with hit held through release.
    step(1, 0, 0);
    step(0, 0, 0);
    wait_green();
    step(0, 0, 1);
    step(0, 0, 1);
    rst = 1'b1;
    step(0, 1, 1);
    chk("mr_green", o_green, 0);
    chk("mr_red", o_red, 0);
    chk("mr_busy", o_busy, 0);
    chk("mr_best", o_best, 13'h1FFF);
    rst = 1'b0;
    step(0, 1, 0);
    step(0, 1, 0);
    chk("mr_held_busy", o_busy, 0);
    chk("mr_held_foul", o_foul, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("mr_restart_red", o_red, 1);
    step(0, 0, 0);

    // DUT B: rounds 9, 5, 12.
    sel = 1'b1; #1;
    step(1, 0, 0);
    chk("b_red", o_red, 1);
    step(0, 0, 0);
    run_table(1'b1);
    chk("b_done", o_done, 1);
    chk("b_best", o_best, 5);
    chk("b_total", o_total, 26);
    chk("b_round", o_round, 12);
    chk("b_idx", o_idx, 2);

    // DUT B timeout: 4-bit counter saturates at 15, next tick fouls.
    step(1, 0, 0);
    step(0, 0, 0);
    wait_green();
    repeat (6) step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("to_round6", o_round, 6);
    wait_green();
    repeat (15) step(0, 0, 1);
    chk("to_green15", o_green, 1);
    chk("to_nofoul15", o_foul, 0);
    step(0, 0, 1);
    chk("to_foul", o_foul, 1);
    chk("to_green_off", o_green, 0);
    chk("to_round_kept", o_round, 6);
    chk("to_idx", o_idx, 1);
    chk("to_total", o_total, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
